// File: rtl/di_reg_terminal.sv
// -----------------------------------------------------------------------------
// di_reg_terminal
//
// Device-side responder for the host-interface di_* bus. Answers one terminal
// address and serves single-word reads and writes against a bank of NUM_REGS
// 32-bit control registers, a read-only event FIFO pop port and a FIFO status
// word. All di_* return outputs are forced to zero when the terminal is not
// addressed, so several instances can be OR-combined onto one return bus.
//
// Address map (di_reg_addr):
//   0 .. NUM_REGS-1 : read/write control registers
//   NUM_REGS        : FIFO pop port (read-only)
//   NUM_REGS+1      : FIFO status, bit31 = sticky overflow, bits15:0 = count
//   anything else   : bad address (status 1)
//
// Ports:
//   ifclk, resetb              clock, asynchronous active-low reset
//   di_term_addr, di_reg_addr  transaction terminal / word address
//   di_len                     transfer length (always 1, ignored)
//   di_read_mode, di_read_req, di_read   host read handshake inputs
//   di_read_rdy, di_reg_datao             read data valid / read data
//   di_write_mode, di_write, di_reg_datai host write handshake inputs
//   di_write_rdy                          terminal can accept the write
//   di_transfer_status         0 OK, 1 bad address, 2 FIFO underflow
//   regs_flat                  register i at bits [32i+31:32i]
//   reg_wr_stb, reg_wr_addr    registered strobe/index after a register write
//   fifo_push, fifo_wdata      user event push
//   fifo_full, fifo_empty      registered FIFO flags
// -----------------------------------------------------------------------------
module di_reg_terminal #(
  parameter logic [15:0] TERM_ADDR    = 16'h0010,
  parameter int          NUM_REGS     = 16,
  parameter int          READ_LATENCY = 2,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic                    ifclk,
  input  logic                    resetb,
  input  logic [15:0]             di_term_addr,
  input  logic [31:0]             di_reg_addr,
  input  logic [31:0]             di_len,
  input  logic                    di_read_mode,
  input  logic                    di_read_req,
  input  logic                    di_read,
  output logic                    di_read_rdy,
  output logic [31:0]             di_reg_datao,
  input  logic                    di_write_mode,
  input  logic                    di_write,
  output logic                    di_write_rdy,
  input  logic [31:0]             di_reg_datai,
  output logic [15:0]             di_transfer_status,
  output logic [32*NUM_REGS-1:0]  regs_flat,
  output logic                    reg_wr_stb,
  output logic [5:0]              reg_wr_addr,
  input  logic                    fifo_push,
  input  logic [31:0]             fifo_wdata,
  output logic                    fifo_full,
  output logic                    fifo_empty
);

  localparam int          PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [31:0] POP_ADDR  = 32'(NUM_REGS);
  localparam logic [31:0] STAT_ADDR = 32'(NUM_REGS + 1);
  localparam logic [PW:0] DEPTH_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RDY} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_cnt;
  logic [31:0]   r_addr;
  logic [31:0]   r_rdata;
  logic [15:0]   r_rstat;

  logic [31:0]   r_regs [NUM_REGS];
  logic          r_wrdy;
  logic          r_wr_stb;
  logic [5:0]    r_wr_addr;

  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  logic          r_ovf;
  logic          r_full;
  logic          r_empty;

  logic          w_sel;
  logic          w_capture;
  logic          w_rd_done;
  logic          w_rd_active;
  logic          w_wr_accept;
  logic          w_pop;
  logic          w_push_ok;
  logic          w_ovf_set;
  logic          w_ovf_clr;
  logic [PW:0]   w_count_next;
  logic [31:0]   w_reg_rd;
  logic [31:0]   w_cap_data;
  logic [15:0]   w_cap_stat;
  logic [15:0]   w_wstat;
  logic          w_unused;

  // Transfer length is fixed at one word, so di_len carries no information.
  assign w_unused = ^di_len;

  assign w_sel       = (di_term_addr == TERM_ADDR);
  assign w_capture   = (r_state == S_WAIT) && (w_next == S_RDY);
  assign w_rd_done   = (r_state == S_RDY) && di_read;
  assign w_rd_active = w_sel && (r_state == S_RDY);

  // Read FSM state register.
  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Read FSM next state. Dropping di_read_mode without di_read while a read
  // is outstanding abandons it with no pop and no overflow clear.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (di_read_req && w_sel) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (!di_read_mode && !di_read) w_next = S_IDLE;
        else if (r_cnt == 4'd0)        w_next = S_RDY;
      end
      S_RDY: begin
        if (di_read || !di_read_mode) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Read data selection, evaluated at the WAIT->RDY transition. The register
  // mux is a compare loop so any NUM_REGS works without index-width tricks.
  always_comb begin
    w_reg_rd   = 32'd0;
    w_cap_data = 32'd0;
    w_cap_stat = 16'd0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (r_addr == 32'(i)) w_reg_rd = r_regs[i];
    end
    if (r_addr < POP_ADDR) begin
      w_cap_data = w_reg_rd;
    end else if (r_addr == POP_ADDR) begin
      if (r_count != '0) w_cap_data = r_mem[r_rptr];
      else               w_cap_stat = 16'd2;
    end else if (r_addr == STAT_ADDR) begin
      w_cap_data = {r_ovf, 15'd0, 16'(r_count)};
    end else begin
      w_cap_stat = 16'd1;
    end
  end

  // Latched read address, latency counter and the captured data/status that
  // stay frozen for the whole RDY phase.
  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      r_cnt   <= 4'd0;
      r_addr  <= 32'd0;
      r_rdata <= 32'd0;
      r_rstat <= 16'd0;
    end else begin
      if ((r_state == S_IDLE) && (w_next == S_WAIT)) begin
        r_addr <= di_reg_addr;
        r_cnt  <= 4'(READ_LATENCY);
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_capture) begin
        r_rdata <= w_cap_data;
        r_rstat <= w_cap_stat;
      end else if (w_next == S_IDLE) begin
        r_rdata <= 32'd0;
        r_rstat <= 16'd0;
      end
    end
  end

  // Only register addresses accept writes; everything else is dropped.
  assign w_wr_accept = di_write && w_sel && (di_reg_addr < POP_ADDR);
  assign w_wstat     = (di_reg_addr < POP_ADDR) ? 16'd0 : 16'd1;

  // Register bank, write-ready flag and the post-write strobe.
  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 32'd0;
      r_wrdy    <= 1'b0;
      r_wr_stb  <= 1'b0;
      r_wr_addr <= 6'd0;
    end else begin
      r_wrdy   <= w_sel && di_write_mode && !di_write;
      r_wr_stb <= w_wr_accept;
      if (w_wr_accept) r_wr_addr <= di_reg_addr[5:0];
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_accept && (di_reg_addr == 32'(i))) r_regs[i] <= di_reg_datai;
      end
    end
  end

  // A pop is only committed when the host completes a read that captured a
  // valid head word. A push into a full FIFO is still accepted when a pop
  // happens on the same edge, so the count stays put and nothing overflows.
  assign w_pop     = w_rd_done && (r_addr == POP_ADDR) && (r_rstat == 16'd0) &&
                     (r_count != '0);
  assign w_push_ok = fifo_push && ((r_count != DEPTH_CNT) || w_pop);
  assign w_ovf_set = fifo_push && !w_push_ok;
  assign w_ovf_clr = w_rd_done && (r_addr == STAT_ADDR);

  always_comb begin
    w_count_next = r_count;
    if (w_push_ok && !w_pop)      w_count_next = r_count + 1'b1;
    else if (!w_push_ok && w_pop) w_count_next = r_count - 1'b1;
  end

  // FIFO storage has no reset; only pointers and flags need a known state.
  always_ff @(posedge ifclk) begin
    if (w_push_ok) r_mem[r_wptr] <= fifo_wdata;
  end

  // FIFO pointers, count, sticky overflow and registered flags. Overflow set
  // wins over a coinciding clear.
  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_next;
      r_ovf   <= w_ovf_set || (r_ovf && !w_ovf_clr);
      r_full  <= (w_count_next == DEPTH_CNT);
      r_empty <= (w_count_next == '0);
    end
  end

  assign di_read_rdy  = w_rd_active;
  assign di_reg_datao = w_rd_active ? r_rdata : 32'd0;
  assign di_write_rdy = w_sel && r_wrdy;
  assign di_transfer_status = w_rd_active         ? r_rstat :
                              (w_sel && r_wrdy)   ? w_wstat : 16'd0;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[32*g +: 32] = r_regs[g];
  end

  assign reg_wr_stb  = r_wr_stb;
  assign reg_wr_addr = r_wr_addr;
  assign fifo_full   = r_full;
  assign fifo_empty  = r_empty;

endmodule

// File: tb/tb_di_reg_terminal.sv
// -----------------------------------------------------------------------------
// tb_di_reg_terminal
//
// Self-checking bench for di_reg_terminal. A behavioural model (register
// array, word queue, overflow bit) tracks what the terminal should hold; each
// test task drives host transactions and compares the DUT against the model.
// -----------------------------------------------------------------------------
module tb_di_reg_terminal;

  localparam logic [15:0] TERM  = 16'h0010;
  localparam int          NREGS = 16;
  localparam int          LAT   = 2;
  localparam int          DEPTH = 8;

  logic                   ifclk;
  logic                   resetb;
  logic [15:0]            di_term_addr;
  logic [31:0]            di_reg_addr;
  logic [31:0]            di_len;
  logic                   di_read_mode;
  logic                   di_read_req;
  logic                   di_read;
  logic                   di_read_rdy;
  logic [31:0]            di_reg_datao;
  logic                   di_write_mode;
  logic                   di_write;
  logic                   di_write_rdy;
  logic [31:0]            di_reg_datai;
  logic [15:0]            di_transfer_status;
  logic [32*NREGS-1:0]    regs_flat;
  logic                   reg_wr_stb;
  logic [5:0]             reg_wr_addr;
  logic                   fifo_push;
  logic [31:0]            fifo_wdata;
  logic                   fifo_full;
  logic                   fifo_empty;

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] m_regs [NREGS];
  logic [31:0] m_fifo [$];
  bit          m_ovf;

  di_reg_terminal #(
    .TERM_ADDR(TERM), .NUM_REGS(NREGS), .READ_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .ifclk(ifclk), .resetb(resetb),
    .di_term_addr(di_term_addr), .di_reg_addr(di_reg_addr), .di_len(di_len),
    .di_read_mode(di_read_mode), .di_read_req(di_read_req), .di_read(di_read),
    .di_read_rdy(di_read_rdy), .di_reg_datao(di_reg_datao),
    .di_write_mode(di_write_mode), .di_write(di_write),
    .di_write_rdy(di_write_rdy), .di_reg_datai(di_reg_datai),
    .di_transfer_status(di_transfer_status), .regs_flat(regs_flat),
    .reg_wr_stb(reg_wr_stb), .reg_wr_addr(reg_wr_addr),
    .fifo_push(fifo_push), .fifo_wdata(fifo_wdata),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty)
  );

  initial begin
    ifclk = 1'b0;
    forever #5 ifclk = ~ifclk;
  end

  // Hard stop in case a transaction wedges the bench.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge ifclk);
    #1;
  endtask

  function automatic logic [32*NREGS-1:0] model_flat();
    logic [32*NREGS-1:0] v;
    v = '0;
    for (int i = 0; i < NREGS; i++) v[32*i +: 32] = m_regs[i];
    return v;
  endfunction

  function automatic logic [31:0] model_status();
    return {m_ovf, 15'd0, 16'(m_fifo.size())};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = 32'd0;
    m_fifo.delete();
    m_ovf = 1'b0;
  endfunction

  // Full host read: request, wait for ready (bounded), sample, complete.
  // lat counts edges after the request edge until di_read_rdy is seen.
  task automatic do_read(input logic [31:0] addr, input bit push_at_done,
                         input logic [31:0] push_data,
                         output logic [31:0] data, output logic [15:0] status,
                         output int lat);
    di_term_addr = TERM;
    di_reg_addr  = addr;
    di_read_mode = 1'b1;
    di_read_req  = 1'b1;
    tick();
    di_read_req = 1'b0;
    lat = 0;
    while (di_read_rdy !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    data   = di_reg_datao;
    status = di_transfer_status;
    di_read    = 1'b1;
    fifo_push  = push_at_done;
    fifo_wdata = push_data;
    tick();
    di_read      = 1'b0;
    di_read_mode = 1'b0;
    fifo_push    = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          output logic [15:0] st_rdy, output logic [15:0] st_wr,
                          output logic rdy_seen);
    di_term_addr  = TERM;
    di_reg_addr   = addr;
    di_reg_datai  = data;
    di_write_mode = 1'b1;
    tick();
    rdy_seen = di_write_rdy;
    st_rdy   = di_transfer_status;
    di_write = 1'b1;
    #1;
    st_wr = di_transfer_status;
    tick();
    di_write      = 1'b0;
    di_write_mode = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] data);
    fifo_push  = 1'b1;
    fifo_wdata = data;
    tick();
    fifo_push = 1'b0;
    if (m_fifo.size() < DEPTH) m_fifo.push_back(data);
    else                       m_ovf = 1'b1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    vectors++;
    if ({di_read_rdy, di_write_rdy, reg_wr_stb, fifo_full, fifo_empty} !== 5'b00001) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got %b, want 00001",
               {di_read_rdy, di_write_rdy, reg_wr_stb, fifo_full, fifo_empty});
    end
    vectors++;
    if ({di_reg_datao, di_transfer_status, reg_wr_addr} !== 54'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: got %h/%h/%h, want 0", di_reg_datao,
               di_transfer_status, reg_wr_addr);
    end
    vectors++;
    if (regs_flat !== model_flat()) begin
      miscompares++;
      $display("[TB] FAIL reset_regs: regs_flat not cleared");
    end
    resetb = 1'b1;
    tick();
  endtask

  task automatic test_reg_rw();
    logic [31:0] d, a;
    logic [15:0] s, sr, sw;
    logic        rs;
    int          lat;
    do_write(32'd3, 32'hCAFEF00D, sr, sw, rs);
    m_regs[3] = 32'hCAFEF00D;
    vectors++;
    if (rs !== 1'b1 || sr !== 16'd0 || sw !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL wr3_handshake: got rdy=%b st=%0d/%0d, want rdy=1 st=0/0", rs, sr, sw);
    end
    vectors++;
    if (reg_wr_stb !== 1'b1 || reg_wr_addr !== 6'd3) begin
      miscompares++;
      $display("[TB] FAIL wr3_stb: got stb=%b addr=%0d, want stb=1 addr=3", reg_wr_stb, reg_wr_addr);
    end
    vectors++;
    if (regs_flat[32*3 +: 32] !== 32'hCAFEF00D) begin
      miscompares++;
      $display("[TB] FAIL wr3_flat: got %h, want cafef00d", regs_flat[32*3 +: 32]);
    end
    tick();
    vectors++;
    if (reg_wr_stb !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wr3_stb_pulse: got %b, want 0", reg_wr_stb);
    end
    do_read(32'd3, 1'b0, 32'd0, d, s, lat);
    vectors++;
    if (lat !== LAT + 1) begin
      miscompares++;
      $display("[TB] FAIL rd3_latency: got %0d, want %0d", lat, LAT + 1);
    end
    vectors++;
    if (d !== 32'hCAFEF00D || s !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL rd3_data: got %h st=%0d, want cafef00d st=0", d, s);
    end
    vectors++;
    if (di_read_rdy !== 1'b0 || di_reg_datao !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL rd3_release: got rdy=%b data=%h, want 0/0", di_read_rdy, di_reg_datao);
    end
    for (int i = 0; i < 6; i++) begin
      a = 32'($urandom_range(0, NREGS - 1));
      d = $urandom;
      do_write(a, d, sr, sw, rs);
      m_regs[a] = d;
      vectors++;
      if (regs_flat !== model_flat() || reg_wr_addr !== a[5:0]) begin
        miscompares++;
        $display("[TB] FAIL rand_write: reg %0d got %h, want %h", a, regs_flat[32*a +: 32], d);
      end
      a = 32'($urandom_range(0, NREGS - 1));
      do_read(a, 1'b0, 32'd0, d, s, lat);
      vectors++;
      if (d !== m_regs[a] || s !== 16'd0) begin
        miscompares++;
        $display("[TB] FAIL rand_read: reg %0d got %h st=%0d, want %h st=0", a, d, s, m_regs[a]);
      end
    end
  endtask

  task automatic test_bad_addr();
    logic [31:0] d, a;
    logic [15:0] s, sr, sw;
    logic        rs;
    int          lat;
    do_read(32'(NREGS + 5), 1'b0, 32'd0, d, s, lat);
    vectors++;
    if (d !== 32'd0 || s !== 16'd1) begin
      miscompares++;
      $display("[TB] FAIL bad_read: got %h st=%0d, want 0 st=1", d, s);
    end
    a = 32'($urandom_range(NREGS + 2, 5000));
    do_read(a, 1'b0, 32'd0, d, s, lat);
    vectors++;
    if (d !== 32'd0 || s !== 16'd1) begin
      miscompares++;
      $display("[TB] FAIL bad_read_rand: addr %0d got %h st=%0d, want 0 st=1", a, d, s);
    end
    do_write(32'(NREGS), $urandom, sr, sw, rs);
    vectors++;
    if (sr !== 16'd1 || sw !== 16'd1 || rs !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL popport_write_status: got rdy=%b st=%0d/%0d, want 1 st=1/1", rs, sr, sw);
    end
    vectors++;
    if (reg_wr_stb !== 1'b0 || regs_flat !== model_flat()) begin
      miscompares++;
      $display("[TB] FAIL popport_write_regs: stb=%b, registers changed or strobe seen", reg_wr_stb);
    end
  endtask

  task automatic test_fifo_overflow();
    logic [31:0] d;
    logic [15:0] s;
    int          lat;
    for (int i = 0; i < DEPTH + 1; i++) begin
      push_word($urandom);
      if (i == DEPTH - 1) begin
        vectors++;
        if (fifo_full !== 1'b1 || fifo_empty !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL fifo_full_flag: got full=%b empty=%b, want 1/0", fifo_full, fifo_empty);
        end
      end
    end
    do_read(32'(NREGS + 1), 1'b0, 32'd0, d, s, lat);
    vectors++;
    if (d !== model_status() || s !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL status_ovf: got %h st=%0d, want %h st=0", d, s, model_status());
    end
    m_ovf = 1'b0;
    do_read(32'(NREGS + 1), 1'b0, 32'd0, d, s, lat);
    vectors++;
    if (d !== model_status() || s !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL status_cleared: got %h st=%0d, want %h st=0", d, s, model_status());
    end
  endtask

  task automatic test_fifo_pop();
    logic [31:0] d, e;
    logic [15:0] s;
    int          lat;
    for (int i = 0; i < DEPTH; i++) begin
      e = m_fifo.pop_front();
      do_read(32'(NREGS), 1'b0, 32'd0, d, s, lat);
      vectors++;
      if (d !== e || s !== 16'd0) begin
        miscompares++;
        $display("[TB] FAIL pop_%0d: got %h st=%0d, want %h st=0", i, d, s, e);
      end
    end
    vectors++;
    if (fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL drained_flags: got empty=%b full=%b, want 1/0", fifo_empty, fifo_full);
    end
    do_read(32'(NREGS), 1'b0, 32'd0, d, s, lat);
    vectors++;
    if (d !== 32'd0 || s !== 16'd2) begin
      miscompares++;
      $display("[TB] FAIL underflow: got %h st=%0d, want 0 st=2", d, s);
    end
  endtask

  task automatic test_push_pop_full();
    logic [31:0] d, e, w;
    logic [15:0] s;
    int          lat;
    for (int i = 0; i < DEPTH; i++) push_word($urandom);
    w = $urandom;
    e = m_fifo.pop_front();
    m_fifo.push_back(w);
    do_read(32'(NREGS), 1'b1, w, d, s, lat);
    vectors++;
    if (d !== e || s !== 16'd0 || fifo_full !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL full_push_pop: got %h st=%0d full=%b, want %h st=0 full=1", d, s, fifo_full, e);
    end
    do_read(32'(NREGS + 1), 1'b0, 32'd0, d, s, lat);
    vectors++;
    if (d !== model_status()) begin
      miscompares++;
      $display("[TB] FAIL full_push_pop_status: got %h, want %h", d, model_status());
    end
    m_ovf = 1'b0;
    while (m_fifo.size() > 0) begin
      e = m_fifo.pop_front();
      do_read(32'(NREGS), 1'b0, 32'd0, d, s, lat);
      vectors++;
      if (d !== e || s !== 16'd0) begin
        miscompares++;
        $display("[TB] FAIL wrap_pop: got %h st=%0d, want %h st=0", d, s, e);
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] d, w;
    logic [15:0] s;
    int          lat;
    bit          seen;
    w = $urandom;
    push_word(w);
    di_term_addr = TERM;
    di_reg_addr  = 32'(NREGS);
    di_read_mode = 1'b1;
    di_read_req  = 1'b1;
    tick();
    di_read_req  = 1'b0;
    di_read_mode = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (di_read_rdy !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("[TB] FAIL abort_rdy: got rdy=1 after abort, want 0");
    end
    do_read(32'(NREGS + 1), 1'b0, 32'd0, d, s, lat);
    vectors++;
    if (d !== model_status()) begin
      miscompares++;
      $display("[TB] FAIL abort_no_pop: got %h, want %h", d, model_status());
    end
    void'(m_fifo.pop_front());
    do_read(32'(NREGS), 1'b0, 32'd0, d, s, lat);
    vectors++;
    if (d !== w || s !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL abort_word_kept: got %h st=%0d, want %h st=0", d, s, w);
    end
  endtask

  task automatic test_not_selected();
    bit leak;
    leak = 1'b0;
    di_term_addr  = TERM + 16'($urandom_range(1, 200));
    di_reg_addr   = 32'd0;
    di_reg_datai  = $urandom;
    di_read_mode  = 1'b1;
    di_read_req   = 1'b1;
    di_write_mode = 1'b1;
    tick();
    di_read_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      di_write = (i == 2);
      #1;
      if ({di_read_rdy, di_write_rdy, di_reg_datao, di_transfer_status, reg_wr_stb} !== 51'd0)
        leak = 1'b1;
      tick();
    end
    di_write      = 1'b0;
    di_read_mode  = 1'b0;
    di_write_mode = 1'b0;
    vectors++;
    if (leak) begin
      miscompares++;
      $display("[TB] FAIL unselected_outputs: got nonzero output, want all 0");
    end
    vectors++;
    if (regs_flat !== model_flat() || reg_wr_stb !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL unselected_regs: got reg0=%h, want %h", regs_flat[31:0], m_regs[0]);
    end
    di_term_addr = TERM;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, a;
    logic [15:0] s, sr, sw;
    logic        rs;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      a = 32'($urandom_range(0, NREGS - 1));
      d = $urandom;
      do_write(a, d, sr, sw, rs);
      m_regs[a] = d;
      do_read(a, 1'b0, 32'd0, d, s, lat);
      vectors++;
      if (d !== m_regs[a] || s !== 16'd0 || lat !== LAT + 1) begin
        miscompares++;
        $display("[TB] FAIL b2b_%0d: reg %0d got %h st=%0d lat=%0d, want %h st=0 lat=%0d",
                 i, a, d, s, lat, m_regs[a], LAT + 1);
      end
    end
  endtask

  task automatic test_reset_in_rdy();
    logic [31:0] d;
    logic [15:0] s;
    int          lat;
    push_word($urandom);
    di_term_addr = TERM;
    di_reg_addr  = 32'(NREGS);
    di_read_mode = 1'b1;
    di_read_req  = 1'b1;
    tick();
    di_read_req = 1'b0;
    lat = 0;
    while (di_read_rdy !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    vectors++;
    if (di_read_rdy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rdy_before_reset: got %b, want 1", di_read_rdy);
    end
    resetb = 1'b0;
    #1;
    model_reset();
    vectors++;
    if ({di_read_rdy, di_reg_datao, di_transfer_status, fifo_empty} !== 50'd1) begin
      miscompares++;
      $display("[TB] FAIL reset_in_rdy: got rdy=%b data=%h st=%0d empty=%b, want 0/0/0/1",
               di_read_rdy, di_reg_datao, di_transfer_status, fifo_empty);
    end
    vectors++;
    if (regs_flat !== model_flat()) begin
      miscompares++;
      $display("[TB] FAIL reset_in_rdy_regs: registers not cleared");
    end
    di_read_mode = 1'b0;
    tick();
    resetb = 1'b1;
    tick();
    do_read(32'(NREGS), 1'b0, 32'd0, d, s, lat);
    vectors++;
    if (d !== 32'd0 || s !== 16'd2) begin
      miscompares++;
      $display("[TB] FAIL post_reset_pop: got %h st=%0d, want 0 st=2", d, s);
    end
  endtask

  initial begin
    resetb        = 1'b0;
    di_term_addr  = TERM;
    di_reg_addr   = 32'd0;
    di_len        = 32'd1;
    di_read_mode  = 1'b0;
    di_read_req   = 1'b0;
    di_read       = 1'b0;
    di_write_mode = 1'b0;
    di_write      = 1'b0;
    di_reg_datai  = 32'd0;
    fifo_push     = 1'b0;
    fifo_wdata    = 32'd0;
    model_reset();

    test_reset();
    test_reg_rw();
    test_bad_addr();
    test_fifo_overflow();
    test_fifo_pop();
    test_push_pop_full();
    test_abort();
    test_not_selected();
    test_back_to_back();
    test_reset_in_rdy();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/di_reg_terminal.md
# di_reg_terminal

Device-side responder for the host-interface `di_*` bus. It decodes one terminal address and serves the host's single-word read and write transactions. It backs those transactions with a bank of `NUM_REGS` 32-bit control registers, a read-only event FIFO and a FIFO status word. It sits behind the host interface that converts MicroBlaze IO accesses into `di_*` transactions. Its `di_*` outputs are zero when the terminal is not selected, so several instances OR-combine onto the shared return bus.

## Interface
- `TERM_ADDR`, 16'h0010, terminal address this instance answers to.
- `NUM_REGS`, 16, number of R/W registers at addresses 0..NUM_REGS-1 (1..64).
- `READ_LATENCY`, 2, idle cycles inserted before `di_read_rdy` (0..15).
- `FIFO_DEPTH`, 8, event FIFO depth in words (power of 2, 2..256).
- `ifclk` in 1: sole clock, all logic on rising edge.
- `resetb` in 1: asynchronous, active-low reset.
- `di_term_addr` in 16: transaction terminal address.
- `di_reg_addr` in 32: word address within terminal.
- `di_len` in 32: transfer length. Always 1; ignored.
- `di_read_mode` in 1: high for the duration of a host read.
- `di_read_req` in 1: one-cycle read request pulse.
- `di_read` in 1: one-cycle read-complete pulse. Host samples `di_reg_datao` and `di_transfer_status` in this cycle.
- `di_read_rdy` out 1: read data valid.
- `di_reg_datao` out 32: read data.
- `di_write_mode` in 1: high for the duration of a host write.
- `di_write` in 1: one-cycle write pulse. `di_reg_datai` is valid in this cycle.
- `di_write_rdy` out 1: terminal can accept the write.
- `di_reg_datai` in 32: write data.
- `di_transfer_status` out 16: 0 = OK, 1 = bad address, 2 = FIFO underflow.
- `regs_flat` out 32*NUM_REGS: register contents. Register i is at bits [32i+31:32i].
- `reg_wr_stb` out 1: one-cycle pulse, registered, after each accepted register write.
- `reg_wr_addr` out 6: index of the register written, valid with `reg_wr_stb`.
- `fifo_push` in 1, `fifo_wdata` in 32: user event push.
- `fifo_full` out 1, `fifo_empty` out 1.

## Operation
- Selection: `sel = (di_term_addr == TERM_ADDR)`. The addresses `di_*` uses are decided as follows.
  - Address A = `di_reg_addr`.
  - A < NUM_REGS: register A.
  - A == NUM_REGS: FIFO pop port.
  - A == NUM_REGS+1: FIFO status. Bit 31 = sticky overflow, bits 15:0 = word count. Read-only; a read clears overflow.
  - Any other A: bad address.
- Read FSM states:
  - IDLE → WAIT on `di_read_req && sel`. Latch A; load counter with READ_LATENCY.
  - WAIT decrements the counter. At 0 it drives `di_reg_datao` and `di_transfer_status` and goes to RDY.
  - RDY holds `di_read_rdy=1` with data and status stable until `di_read`. It then returns to IDLE, and all three outputs are 0 on the next cycle.
  - From WAIT or RDY, `di_read_mode` low without `di_read` is an abort: go to IDLE with no side effects.
- Read data per address:
  - Register: its value, status 0.
  - FIFO pop port, non-empty: head word, status 0. Pop occurs on the `di_read` cycle.
  - FIFO pop port, empty: data 0, status 2, no pop.
  - Bad address: data 0, status 1.
  - Data is captured at WAIT→RDY. A FIFO head or register change during RDY does not alter `di_reg_datao`.
- Write path:
  - `di_write_rdy` is registered: `sel && di_write_mode && !di_write`. It drops the cycle after `di_write`.
  - On `di_write && sel` with A < NUM_REGS: register A ← `di_reg_datai`, `reg_wr_stb` pulses next cycle, status 0.
  - For any other A the write is dropped, status 1.
  - Status is presented from the first `di_write_rdy` cycle through the `di_write` cycle.
- FIFO:
  - Push when full: data is dropped and overflow is set.
  - Simultaneous push and pop are both honoured; count is unchanged, even when full.
  - Pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.
  - An overflow-clearing read coinciding with an overflowing push leaves overflow set.
- Not selected: `di_read_rdy`, `di_write_rdy`, `di_reg_datao` and `di_transfer_status` are all 0.

## Timing
- Reset: all registers, FIFO pointers, count, overflow and the FSM clear immediately. All outputs go to 0, except `fifo_empty=1`.
- Reset mid-transaction abandons it; no register write or pop occurs.
- Read: `di_read_req` sampled at edge k gives `di_read_rdy` high after edge k+READ_LATENCY+1.
- `di_read` at edge m gives `di_read_rdy=0` after edge m+1.
- Write: `di_write_mode` rising at edge k gives `di_write_rdy` after edge k+1.
- After `di_write` at edge m, `regs_flat` and `reg_wr_stb` update at edge m+1.
- `fifo_full` and `fifo_empty` are registered and reflect the count after each edge.

## Test plan
- Write 32'hCAFEF00D to reg 3, then read reg 3 with READ_LATENCY=2.
  - Required: `reg_wr_stb` with `reg_wr_addr`=3, then `di_read_rdy` 3 cycles after req, data CAFEF00D, status 0.
- Read A=NUM_REGS+5.
  - Required: data 0, status 1.
- Write A=NUM_REGS (the FIFO pop port).
  - Required: status 1, no register change.
- Push 9 words into an 8-deep FIFO, then read status, then read status again.
  - Required: first status read returns 32'h80000008; second returns 32'h00000008.
- Pop 8 words, then pop once more.
  - Required: words returned in push order; the 9th word was dropped on overflow.
  - The extra pop returns data 0, status 2.
- Issue `di_read_req`, then drop `di_read_mode` while in WAIT; separately, access with `di_term_addr`≠TERM_ADDR; separately, assert reset while in RDY.
  - Required: the aborted read causes no pop.
  - The non-matching access leaves all outputs at 0.
  - Reset while in RDY clears outputs.
